dot_max_scheduler: RTL and testbench
====================================

Name: dot_max_scheduler

Overview:
Shared sequencer for the nibble dot-product / running-maximum datapath. Two requesters submit packed weight and input vectors over valid/ready. A round-robin arbiter grants one request at a time. The block runs one lane-multiply-accumulate per cycle, emits the dot product, and maintains a running maximum across all results with a synchronous clear.

Parameters:
LANES, 4, number of nibble lanes per vector (power of two, ≥2).
NIB, 4, bits per lane operand.
VEC_W, LANES*NIB, derived width of one weight or input vector.
ACC_W, 2*NIB+log2(LANES), derived accumulator/result width (10 at defaults).

Ports:
clk  in  1  single clock, all state on rising edge.
rst_n  in  1  synchronous active-low reset.
req0_valid  in  1  requester 0 has a vector pair.
req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
req0_w  in  VEC_W  requester 0 weights; lane i = bits [i*NIB +: NIB].
req0_x  in  VEC_W  requester 0 inputs, same lane packing.
req1_valid / req1_ready / req1_w / req1_x  same as requester 0.
clear_max  in  1  synchronous clear of running maximum.
res_valid  out  1  one-cycle result strobe.
res_src  out  1  requester index of current result.
res_dot  out  ACC_W  dot product sum_i w[i]*x[i], unsigned.
res_new_max  out  1  with res_valid: res_dot strictly exceeds stored max.
res_max  out  ACC_W  stored running maximum.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, acc=0, lane index=0, res_dot=0, res_src=0, res_max=0, res_valid=0, res_new_max=0, busy=0, last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE → MAC → DONE → IDLE.
- IDLE grant rule:
  - If only one valid is high, grant that requester.
  - If both are high, grant the one not equal to last_grant.
- IDLE readys: req*_ready is combinational, high only for the granted requester and only in IDLE; both are low in all other states.
- Accept:
  - On an edge with valid&ready, latch w and x into internal operand registers, record res_src and last_grant.
  - Set acc=0 and lane index=0, then go to MAC.
  - Inputs need not be held after acceptance.
- MAC:
  - Each cycle, acc += w[idx]*x[idx] (NIB×NIB unsigned product, zero-extended to ACC_W; no overflow is possible), then idx++.
  - After the lane LANES-1 update, go to DONE. MAC occupies exactly LANES cycles.
- DONE (one cycle):
  - res_valid=1 and res_dot=acc.
  - res_new_max = (acc > res_max), combinational on current registers; ties do not count as new max.
  - At the edge leaving DONE, res_max <= acc if res_new_max. State returns to IDLE.
  - During DONE, res_max shows the prior value.
- Latency and throughput:
  - Accept edge at cycle T; MAC is T+1..T+LANES; res_valid is high in cycle T+LANES+1.
  - The next accept is possible at the edge ending cycle T+LANES+2.
  - Throughput is one request per LANES+2 cycles (6 at defaults).
- Results have no backpressure; res_valid is a single-cycle pulse.
- res_dot and res_src hold their values until the next DONE.
- clear_max:
  - Sets res_max=0 at the next edge in any state.
  - If asserted in DONE, the clear wins (res_max becomes 0), but res_new_max still reflects comparison against the pre-clear value.
- Reset mid-transaction:
  - An accepted but unfinished request is dropped silently and no res_valid is produced.
  - Reset has priority over all other events.
- Valid deassertion before grant is allowed; there is no stickiness requirement on requesters.

Test Plan:
- Req0 only, w=0xFFFF, x=0xFFFF → one req0_ready pulse; res_valid exactly 5 cycles after accept edge; res_dot=900, res_src=0, res_new_max=1; res_max=900 the following cycle.
- Req1 only, w=0x4321, x=0x1111, after previous test → res_dot=10, res_new_max=0, res_max stays 900.
- Both requesters held valid continuously for 4 transactions from reset → grant order 0,1,0,1; results spaced 6 cycles apart; the non-granted ready is never high.
- Equal results: two submissions of w=0x0002, x=0x0003 (dot 6) from reset → first gives new_max=1, second gives new_max=0; res_max=6.
- clear_max asserted in the DONE cycle of a dot=50 result with res_max=20 → res_new_max=1, res_max=0 next cycle; clear_max in IDLE → res_max=0.
- rst_n low for one cycle during MAC (cycle T+2) → no res_valid; busy=0 and res_max=0 after reset; a new request is then processed normally.

Source files
------------

// File: rtl/dot_max_scheduler.sv
// Two-requester round-robin sequencer for a nibble dot-product datapath.
// One lane multiply-accumulate per cycle; tracks a running maximum of results.
module dot_max_scheduler #(
    parameter int LANES = 4,
    parameter int NIB   = 4,
    parameter int VEC_W = LANES * NIB,
    parameter int ACC_W = 2 * NIB + $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [VEC_W-1:0] req0_w,
    input  logic [VEC_W-1:0] req0_x,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [VEC_W-1:0] req1_w,
    input  logic [VEC_W-1:0] req1_x,
    input  logic             clear_max,
    output logic             res_valid,
    output logic             res_src,
    output logic [ACC_W-1:0] res_dot,
    output logic             res_new_max,
    output logic [ACC_W-1:0] res_max,
    output logic             busy
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [VEC_W-1:0] w_reg, x_reg;
    logic [ACC_W-1:0] acc_reg, res_dot_reg, res_max_reg;
    logic             res_src_reg, last_grant_reg;
    logic             grant, accept, last_lane;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] lane_prod [LANES];

    // All lane products are formed in parallel; the MAC walks them by index.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [2*NIB-1:0] prod;
            assign prod = w_reg[gi*NIB +: NIB] * x_reg[gi*NIB +: NIB];
            assign lane_prod[gi] = {{(ACC_W-2*NIB){1'b0}}, prod};
        end
    endgenerate

    assign acc_sum   = acc_reg + lane_prod[idx_reg];
    assign last_lane = (idx_reg == IDX_W'(LANES - 1));

    // On contention the requester not served last time wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end
        accept = (state_reg == IDLE) && (req0_valid || req1_valid);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (last_lane) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready  = accept && !grant;
    assign req1_ready  = accept && grant;
    assign res_valid   = (state_reg == DONE);
    assign res_new_max = res_valid && (acc_reg > res_max_reg);
    assign res_dot     = res_dot_reg;
    assign res_src     = res_src_reg;
    assign res_max     = res_max_reg;
    assign busy        = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            w_reg          <= '0;
            x_reg          <= '0;
            acc_reg        <= '0;
            res_dot_reg    <= '0;
            res_max_reg    <= '0;
            res_src_reg    <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                w_reg          <= grant ? req1_w : req0_w;
                x_reg          <= grant ? req1_x : req0_x;
                res_src_reg    <= grant;
                last_grant_reg <= grant;
                acc_reg        <= '0;
                idx_reg        <= '0;
            end else if (state_reg == MAC) begin
                acc_reg <= acc_sum;
                idx_reg <= idx_reg + 1'b1;
                if (last_lane) begin
                    res_dot_reg <= acc_sum;
                end
            end
            // Clear beats a simultaneous new maximum.
            if (clear_max) begin
                res_max_reg <= '0;
            end else if (res_new_max) begin
                res_max_reg <= acc_reg;
            end
        end
    end
endmodule

// File: tb/tb_dot_max_scheduler.sv
// Randomized and directed bench for dot_max_scheduler against a transaction-level model.
module tb_dot_max_scheduler;
    localparam int LANES = 4;
    localparam int NIB   = 4;
    localparam int VEC_W = 16;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [VEC_W-1:0] req0_w, req0_x, req1_w, req1_x;
    logic             clear_max, res_valid, res_src, res_new_max, busy;
    logic [ACC_W-1:0] res_dot, res_max;

    always #5 clk = ~clk;

    dot_max_scheduler #(.LANES(LANES), .NIB(NIB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_w(req0_w), .req0_x(req0_x),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_w(req1_w), .req1_x(req1_x),
        .clear_max(clear_max), .res_valid(res_valid), .res_src(res_src), .res_dot(res_dot),
        .res_new_max(res_new_max), .res_max(res_max), .busy(busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Model: cycles left in the current job (LANES MAC + 1 DONE), arbitration and max state.
    int m_cnt   = 0;
    int m_last  = 1;
    int m_max   = 0;
    int m_dot   = 0;
    int m_src   = 0;
    bit m_known = 1'b0;

    int ev_dot[$], ev_src[$], ev_new[$], ev_cyc[$], gr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int ref_dot(input logic [VEC_W-1:0] w, input logic [VEC_W-1:0] x);
        int s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += ((int'(w) >> (i * NIB)) & 15) * ((int'(x) >> (i * NIB)) & 15);
        end
        return s;
    endfunction

    task automatic cycle(input logic v0, input logic [VEC_W-1:0] w0, input logic [VEC_W-1:0] x0,
                         input logic v1, input logic [VEC_W-1:0] w1, input logic [VEC_W-1:0] x1,
                         input logic clr, input logic rst);
        bit idle_s, done_s, e_r0, e_r1;
        req0_valid = v0; req0_w = w0; req0_x = x0;
        req1_valid = v1; req1_w = w1; req1_x = x1;
        clear_max = clr; rst_n = !rst;
        #1;
        idle_s = (m_cnt == 0);
        done_s = (m_cnt == 1);
        e_r0 = idle_s && v0 && (!v1 || m_last == 1);
        e_r1 = idle_s && v1 && (!v0 || m_last == 0);
        if (m_known) begin
            check("ready0", req0_ready, e_r0);
            check("ready1", req1_ready, e_r1);
            check("res_valid", res_valid, done_s);
            check("busy", busy, !idle_s);
            check("res_max", res_max, m_max);
            if (done_s) begin
                check("res_dot", res_dot, m_dot);
                check("res_src", res_src, m_src);
                check("new_max", res_new_max, m_dot > m_max);
            end
        end
        if (res_valid) begin
            ev_dot.push_back(int'(res_dot)); ev_src.push_back(int'(res_src));
            ev_new.push_back(int'(res_new_max)); ev_cyc.push_back(cyc);
        end
        if (req0_valid && req0_ready) gr.push_back(0);
        if (req1_valid && req1_ready) gr.push_back(1);
        if (rst) begin
            m_cnt = 0; m_last = 1; m_max = 0; m_known = 1'b1;
        end else if (m_known) begin
            if (done_s && m_dot > m_max) m_max = m_dot;
            if (clr) m_max = 0;
            if (e_r0 || e_r1) begin
                m_src  = e_r1 ? 1 : 0;
                m_last = m_src;
                m_dot  = e_r1 ? ref_dot(w1, x1) : ref_dot(w0, x0);
                m_cnt  = LANES + 1;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic clear_log();
        ev_dot.delete(); ev_src.delete(); ev_new.delete(); ev_cyc.delete(); gr.delete();
    endtask

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    initial begin
        int c0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_dot", res_dot, 0);
        check("rst_src", res_src, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);

        // Single requester 0, all-ones vectors.
        clear_log();
        c0 = cyc;
        cycle(1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0);
        idle(7);
        check("tp1_events", ev_dot.size(), 1);
        check("tp1_dot", last_of(ev_dot), 900);
        check("tp1_src", last_of(ev_src), 0);
        check("tp1_new", last_of(ev_new), 1);
        check("tp1_latency", last_of(ev_cyc) - c0, LANES + 1);
        check("tp1_grants", gr.size(), 1);
        check("tp1_max", res_max, 900);

        // Single requester 1, smaller result.
        clear_log();
        cycle(0, 0, 0, 1, 16'h4321, 16'h1111, 0, 0);
        idle(7);
        check("tp2_dot", last_of(ev_dot), 10);
        check("tp2_src", last_of(ev_src), 1);
        check("tp2_new", last_of(ev_new), 0);
        check("tp2_max", res_max, 900);

        // Both requesters held valid: alternating grants, one result every LANES+2 cycles.
        do_reset();
        clear_log();
        for (int i = 0; i < 24; i++) cycle(1, 16'($urandom), 16'($urandom), 1, 16'($urandom), 16'($urandom), 0, 0);
        check("tp3_grants", gr.size(), 4);
        for (int i = 0; i < 4 && i < gr.size(); i++) check("tp3_order", gr[i], i % 2);
        check("tp3_results", ev_cyc.size(), 4);
        for (int i = 1; i < ev_cyc.size(); i++) check("tp3_spacing", ev_cyc[i] - ev_cyc[i-1], LANES + 2);

        // Equal results: a tie is not a new maximum.
        do_reset();
        clear_log();
        cycle(1, 16'h0002, 16'h0003, 0, 0, 0, 0, 0);
        idle(6);
        cycle(1, 16'h0002, 16'h0003, 0, 0, 0, 0, 0);
        idle(6);
        check("tp4_events", ev_new.size(), 2);
        if (ev_new.size() == 2) begin
            check("tp4_first_new", ev_new[0], 1);
            check("tp4_second_new", ev_new[1], 0);
        end
        check("tp4_max", res_max, 6);

        // clear_max in the DONE cycle, then in IDLE.
        do_reset();
        clear_log();
        cycle(1, 16'h0005, 16'h0004, 0, 0, 0, 0, 0);
        idle(6);
        check("tp5_max20", res_max, 20);
        cycle(0, 0, 0, 1, 16'h0055, 16'h0055, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, m_cnt == 1, 0);
        check("tp5_dot", last_of(ev_dot), 50);
        check("tp5_new", last_of(ev_new), 1);
        check("tp5_cleared", res_max, 0);
        cycle(1, 16'h0055, 16'h0055, 0, 0, 0, 0, 0);
        idle(6);
        check("tp5_max50", res_max, 50);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        check("tp5_idle_clear", res_max, 0);

        // Reset during MAC drops the job.
        do_reset();
        cycle(1, 16'h0003, 16'h0003, 0, 0, 0, 0, 0);
        idle(6);
        check("tp6_premax", res_max, 9);
        clear_log();
        cycle(1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);
        check("tp6_no_result", ev_dot.size(), 0);
        check("tp6_busy", busy, 0);
        check("tp6_max", res_max, 0);
        cycle(1, 16'h1111, 16'h2222, 0, 0, 0, 0, 0);
        idle(6);
        check("tp6_after_dot", last_of(ev_dot), 8);
        check("tp6_after_new", last_of(ev_new), 1);

        // Random traffic with occasional clears and resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
